// File: rtl/kronos_exwb_trace.sv
// Passive execute->writeback trace tap: captures retiring EX records into a
// small FIFO with sticky overflow and a saturating drop counter.
package kronos_types;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result1;
        logic [4:0]  rd;
        logic        rd_write;
        logic        is_illegal;
        logic        ecall;
        logic        ebreak;
        logic        ret;
        logic        wfi;
        logic        csr;
        logic        ld;
        logic        st;
    } pipeEXWB_t;
endpackage

module kronos_exwb_trace
    import kronos_types::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  pipeEXWB_t                  execute,
    input  logic                       execute_vld,
    input  logic                       execute_rdy,
    input  logic                       trace_en,
    input  logic                       trace_clr,
    output logic                       trace_vld,
    input  logic                       trace_rdy,
    output logic [71:0]                trace_data,
    output logic [$clog2(DEPTH):0]     trace_level,
    output logic                       trace_ovf,
    output logic [7:0]                 trace_drops
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    logic [71:0]   mem [DEPTH];
    logic [71:0]   head_data;
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          ovf;
    logic [7:0]    drops;

    logic          fire;
    logic          pop;
    logic          full;
    logic          push;
    logic          drop;
    logic [2:0]    kind;
    logic [4:0]    rd_field;
    logic [71:0]   entry;
    logic [AW-1:0] rd_addr;

    always_comb begin
        kind = 3'd0;
        if (execute.is_illegal)                kind = 3'd7;
        else if (execute.ecall)                kind = 3'd6;
        else if (execute.ebreak)               kind = 3'd5;
        else if (execute.ret || execute.wfi)   kind = 3'd4;
        else if (execute.csr)                  kind = 3'd3;
        else if (execute.ld)                   kind = 3'd2;
        else if (execute.st)                   kind = 3'd1;
    end

    assign rd_field = execute.rd_write ? execute.rd : 5'd0;
    assign entry    = {execute.pc, execute.result1, rd_field, kind};

    assign trace_level = wptr - rptr;
    assign trace_vld   = (wptr != rptr);
    assign full        = (trace_level == FULL_LVL);
    assign fire        = execute_vld && execute_rdy && trace_en;
    assign pop         = trace_vld && trace_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push        = fire && (!full || pop) && !trace_clr;
    assign drop        = fire && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            ovf   <= 1'b0;
            drops <= 8'd0;
        end else if (trace_clr) begin
            wptr  <= '0;
            rptr  <= '0;
            ovf   <= 1'b0;
            drops <= 8'd0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            if (drop) begin
                ovf <= 1'b1;
                if (drops != 8'hFF) drops <= drops + 8'd1;
            end
        end
    end

    // Registered head read: look ahead to the next read pointer and bypass
    // the write when it targets that same slot (push into an emptying FIFO).
    assign rd_addr = pop ? rptr[AW-1:0] + AW'(1) : rptr[AW-1:0];

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= entry;
        if (push && (wptr[AW-1:0] == rd_addr)) head_data <= entry;
        else                                   head_data <= mem[rd_addr];
    end

    assign trace_data  = head_data;
    assign trace_ovf   = ovf;
    assign trace_drops = drops;
endmodule

// File: tb/tb_kronos_exwb_trace.sv
// Self-checking bench for kronos_exwb_trace: table-driven entry encoding plus
// a queue scoreboard checked every cycle, and hand sequences for FIFO corners.
module tb_kronos_exwb_trace;
    import kronos_types::*;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    pipeEXWB_t        execute;
    logic             execute_vld;
    logic             execute_rdy;
    logic             trace_en;
    logic             trace_clr;
    logic             trace_vld;
    logic             trace_rdy;
    logic [71:0]      trace_data;
    logic [LW-1:0]    trace_level;
    logic             trace_ovf;
    logic [7:0]       trace_drops;

    kronos_exwb_trace #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .execute     (execute),
        .execute_vld (execute_vld),
        .execute_rdy (execute_rdy),
        .trace_en    (trace_en),
        .trace_clr   (trace_clr),
        .trace_vld   (trace_vld),
        .trace_rdy   (trace_rdy),
        .trace_data  (trace_data),
        .trace_level (trace_level),
        .trace_ovf   (trace_ovf),
        .trace_drops (trace_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wr;
        logic [7:0]  flags;   // illegal,ecall,ebreak,ret,wfi,csr,ld,st
        logic [71:0] exp_data;
    } vec_t;

    int          passed = 0;
    int          total  = 0;
    logic [71:0] sb_q[$];
    logic        m_ovf;
    logic [7:0]  m_drops;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic pipeEXWB_t make_ex(input logic [31:0] pc, input logic [31:0] res,
                                          input logic [4:0] rd, input logic wr,
                                          input logic [7:0] f);
        pipeEXWB_t e;
        e.pc = pc; e.result1 = res; e.rd = rd; e.rd_write = wr;
        e.is_illegal = f[7]; e.ecall = f[6]; e.ebreak = f[5]; e.ret = f[4];
        e.wfi = f[3]; e.csr = f[2]; e.ld = f[1]; e.st = f[0];
        return e;
    endfunction

    function automatic logic [71:0] model_entry(input pipeEXWB_t e);
        logic [2:0] k;
        if (e.is_illegal)        k = 7;
        else if (e.ecall)        k = 6;
        else if (e.ebreak)       k = 5;
        else if (e.ret || e.wfi) k = 4;
        else if (e.csr)          k = 3;
        else if (e.ld)           k = 2;
        else if (e.st)           k = 1;
        else                     k = 0;
        return {e.pc, e.result1, (e.rd_write ? e.rd : 5'd0), k};
    endfunction

    // Drive one cycle's inputs, update the reference model, then check after the edge.
    task automatic cycle(input pipeEXWB_t ex, input logic vld, input logic erdy,
                         input logic en, input logic clr, input logic trdy);
        logic fire_m, full_m, pop_m;
        execute = ex; execute_vld = vld; execute_rdy = erdy;
        trace_en = en; trace_clr = clr; trace_rdy = trdy;
        fire_m = vld && erdy && en;
        if (trdy && sb_q.size() > 0) check("pop_data", trace_data, sb_q[0]);
        if (clr) begin
            sb_q.delete();
            m_ovf = 1'b0;
            m_drops = 8'd0;
        end else begin
            full_m = (sb_q.size() == DEPTH);
            pop_m  = trdy && (sb_q.size() > 0);
            if (pop_m) void'(sb_q.pop_front());
            if (fire_m) begin
                if (!full_m || pop_m) sb_q.push_back(model_entry(ex));
                else begin
                    m_ovf = 1'b1;
                    if (m_drops != 8'hFF) m_drops = m_drops + 8'd1;
                end
            end
        end
        @(posedge clk);
        #2;
        check("vld", trace_vld, sb_q.size() != 0);
        check("level", trace_level, sb_q.size());
        check("ovf", trace_ovf, m_ovf);
        check("drops", trace_drops, m_drops);
    endtask

    task automatic idle(input logic trdy);
        cycle(make_ex(0, 0, 0, 0, 0), 0, 0, 0, 0, trdy);
    endtask

    task automatic fire_pc(input logic [31:0] pc, input logic trdy);
        cycle(make_ex(pc, ~pc, pc[6:2], 1'b1, 8'h00), 1, 1, 1, 0, trdy);
    endtask

    task automatic clear();
        cycle(make_ex(0, 0, 0, 0, 0), 0, 0, 0, 1, 0);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h100, 32'hDEADBEEF, 5'd5,  1'b1, 8'h00, 72'h00000100_DEADBEEF_28};
        vecs[1] = '{32'h104, 32'h0,        5'd7,  1'b0, 8'h82, 72'h00000104_00000000_07};
        vecs[2] = '{32'h108, 32'h1,        5'd31, 1'b1, 8'h60, 72'h00000108_00000001_FE};
        vecs[3] = '{32'h10C, 32'h2,        5'd1,  1'b1, 8'h24, 72'h0000010C_00000002_0D};
        vecs[4] = '{32'h110, 32'h3,        5'd2,  1'b1, 8'h08, 72'h00000110_00000003_14};
        vecs[5] = '{32'h114, 32'h4,        5'd3,  1'b0, 8'h11, 72'h00000114_00000004_04};
        vecs[6] = '{32'h118, 32'h5,        5'd4,  1'b1, 8'h06, 72'h00000118_00000005_23};
        vecs[7] = '{32'h11C, 32'h6,        5'd6,  1'b1, 8'h03, 72'h0000011C_00000006_32};
        vecs[8] = '{32'h120, 32'h7,        5'd8,  1'b1, 8'h01, 72'h00000120_00000007_41};

        rst = 1'b1;
        execute = make_ex(0, 0, 0, 0, 0);
        execute_vld = 0; execute_rdy = 0; trace_en = 0; trace_clr = 0; trace_rdy = 0;
        m_ovf = 1'b0; m_drops = 8'd0;
        #3;
        check("rst_vld", trace_vld, 0);
        check("rst_level", trace_level, 0);
        check("rst_ovf", trace_ovf, 0);
        check("rst_drops", trace_drops, 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Entry encoding: one fire, check head against the table, then pop it.
        for (int i = 0; i < 9; i++) begin
            cycle(make_ex(vecs[i].pc, vecs[i].res, vecs[i].rd, vecs[i].wr, vecs[i].flags),
                  1, 1, 1, 0, 0);
            check($sformatf("vec%0d_data", i), trace_data, vecs[i].exp_data);
            check($sformatf("vec%0d_level", i), trace_level, 1);
            idle(1);
        end

        // Overfill: 10 fires, no pops.
        clear();
        for (int i = 0; i < 10; i++) fire_pc(32'h200 + 32'(i * 4), 0);
        check("ovf_level", trace_level, DEPTH);
        check("ovf_flag", trace_ovf, 1);
        check("ovf_drops", trace_drops, 2);
        // Full FIFO: fire and pop in the same cycle.
        fire_pc(32'h300, 1);
        check("fullpp_level", trace_level, DEPTH);
        check("fullpp_head", trace_data[71:40], 32'h204);
        for (int i = 0; i < DEPTH; i++) idle(1);
        check("drain_level", trace_level, 0);

        // Drop counter saturation, then clear coincident with a fire.
        clear();
        for (int i = 0; i < DEPTH + 300; i++) fire_pc(32'h1000 + 32'(i * 4), 0);
        check("sat_drops", trace_drops, 8'hFF);
        check("sat_ovf", trace_ovf, 1);
        cycle(make_ex(32'h2000, 32'h1, 5'd1, 1'b1, 8'h00), 1, 1, 1, 1, 0);
        check("clr_level", trace_level, 0);
        check("clr_vld", trace_vld, 0);
        check("clr_ovf", trace_ovf, 0);
        check("clr_drops", trace_drops, 0);
        idle(0);
        check("clr_nowrite", trace_level, 0);

        // Asynchronous reset between edges with three entries held.
        for (int i = 0; i < 3; i++) fire_pc(32'h3000 + 32'(i * 4), 0);
        check("pre_rst_level", trace_level, 3);
        #2 rst = 1'b1;
        #1;
        check("arst_vld", trace_vld, 0);
        check("arst_level", trace_level, 0);
        #1 rst = 1'b0;
        sb_q.delete(); m_ovf = 1'b0; m_drops = 8'd0;
        // No capture without writeback ready or with capture disabled.
        cycle(make_ex(32'h500, 32'h5, 5'd5, 1'b1, 8'h00), 1, 0, 1, 0, 0);
        cycle(make_ex(32'h504, 32'h5, 5'd5, 1'b1, 8'h00), 1, 1, 0, 0, 0);
        check("nocap_level", trace_level, 0);
        // First fire after reset is the head entry.
        fire_pc(32'h400, 0);
        check("post_rst_data", trace_data, 72'h00000400_FFFFFBFF_00);
        fire_pc(32'h404, 0);
        // Pops keep working while capture is disabled.
        cycle(make_ex(32'h508, 32'h5, 5'd5, 1'b1, 8'h00), 1, 1, 0, 0, 1);
        check("en0_pop_level", trace_level, 1);
        check("en0_pop_head", trace_data[71:40], 32'h404);
        idle(1);
        idle(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/kronos_exwb_trace.md
KRONOS_EXWB_TRACE -- requirements
Module: kronos_exwb_trace

Interface
REQ-001 Parameter: DEPTH, default 8, trace FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Port: clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: execute  in  pipeEXWB_t (kronos_types)  execute-stage output record, snooped passively.
REQ-005 Port: execute_vld  in  1  execute record valid.
REQ-006 Port: execute_rdy  in  1  writeback ready; the block SHALL only observe it and SHALL never drive it.
REQ-007 Port: trace_en  in  1  capture enable.
REQ-008 Port: trace_clr  in  1  synchronous flush of FIFO and overflow state.
REQ-009 Port: trace_vld  out  1  head entry valid.
REQ-010 Port: trace_rdy  in  1  consumer pops head when trace_vld && trace_rdy.
REQ-011 Port: trace_data  out  72  head entry.
REQ-012 Port: trace_level  out  $clog2(DEPTH)+1  current occupancy.
REQ-013 Port: trace_ovf  out  1  sticky overflow flag.
REQ-014 Port: trace_drops  out  8  saturating dropped-record count.

Function
REQ-015 Capture event ("fire") SHALL be execute_vld && execute_rdy && trace_en in the same cycle.
REQ-016 Entry layout SHALL be [71:40] execute.pc, [39:8] execute.result1, [7:3] rd field, [2:0] kind.
REQ-017 rd field SHALL equal execute.rd when execute.rd_write=1, else 5'd0.
REQ-018 kind SHALL be priority-encoded, highest first: is_illegal=7, ecall=6, ebreak=5, ret or wfi=4, csr=3, ld=2, st=1, otherwise 0 (ALU/branch).
REQ-019 On fire with FIFO not full, entry SHALL be written at the tail; trace_vld SHALL assert on the next cycle at the earliest (1-cycle write latency, no same-cycle bypass).
REQ-020 trace_data SHALL be the oldest unpopped entry while trace_vld=1; value when trace_vld=0 is don't-care.
REQ-021 Pop SHALL occur on trace_vld && trace_rdy; head advances next cycle.
REQ-022 Simultaneous fire and pop SHALL both take effect; occupancy unchanged, including when full (pop frees the slot, push accepted).
REQ-023 Fire when full and no pop SHALL drop the record, set trace_ovf, and increment trace_drops, saturating at 8'hFF.
REQ-024 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be distinguished via an extra pointer MSB, trace_level = wptr - rptr.
REQ-025 trace_clr SHALL take priority over fire and pop in the same cycle: next cycle level=0, trace_vld=0, trace_ovf=0, trace_drops=0; the coincident record SHALL be discarded and not counted as a drop.
REQ-026 trace_en=0 SHALL inhibit capture only; pops, level and flags SHALL continue to operate.
REQ-027 State SHALL be EMPTY (level 0), PARTIAL, FULL (level DEPTH), derived from pointers; transitions only via REQ-019/021/022/025.

Reset
REQ-028 Asserting rst SHALL immediately force trace_vld=0, trace_level=0, trace_ovf=0, trace_drops=0 and both pointers to 0, regardless of clk.
REQ-029 FIFO storage SHALL NOT require reset; contents after reset are unobservable.
REQ-030 Reset mid-operation SHALL discard all entries; first fire after rst deasserts SHALL land at entry 0.

Verification
REQ-031 Reset, one fire with pc=32'h100, result1=32'hDEAD_BEEF, rd=5, rd_write=1, plain ALU -> next cycle trace_vld=1, trace_data=72'h00000100_DEADBEEF_28, level=1.
REQ-032 Fire with rd=7, rd_write=0, ld=1 and is_illegal=1 -> rd field 0, kind 7.
REQ-033 DEPTH=8, 10 fires with trace_rdy=0 -> level=8, trace_ovf=1, trace_drops=2; pops return first 8 pcs in order.
REQ-034 FIFO full, fire and pop in same cycle -> level stays 8, new record appears after the 7 older ones.
REQ-035 300 fires into full FIFO -> trace_drops=8'hFF; then trace_clr coincident with a fire -> level=0, ovf=0, drops=0, no entry written.
REQ-036 Async rst pulse between clock edges while level=3 -> trace_vld and level drop to 0 before next edge; execute_vld=1 with execute_rdy=0 or trace_en=0 -> no capture.
